// File: rtl/tail_light_input_conditioner.sv
// Input conditioner for the T-bird tail-light FSM.
// Synchronises and debounces the left/right lever contacts and the hazard pushbutton,
// turns the pushbutton into a latched hazard toggle and arbitrates registered LEFT/RIGHT/HAZ.
// Optional feature: define TL_HAZ_TIMEOUT_EN to make a latched hazard self-clear after
// HAZ_TIMEOUT_CYCLES clock cycles.
module tail_light_input_conditioner #(
    parameter int unsigned DEB_CYCLES         = 16,
    parameter int unsigned HAZ_TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left_sw,
    input  logic right_sw,
    input  logic haz_btn,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ,
    output logic CONFLICT
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    // Bit 0 = left lever, bit 1 = right lever, bit 2 = hazard button.
    logic [2:0]            w_raw;
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_stable;
    logic [2:0]            w_stable_d;
    logic [2:0]            w_accept;
    logic [2:0][CNT_W-1:0] r_cnt;
    logic [2:0][CNT_W-1:0] w_cnt_d;

    typedef enum logic {StBtnUp, StBtnDown} btn_state_e;
    btn_state_e r_btn;
    btn_state_e w_btn_d;
    logic       w_toggle;

    logic r_haz;
    logic w_haz_d;

    logic r_left;
    logic r_right;
    logic r_hazo;
    logic r_conflict;

    assign w_raw = {haz_btn, right_sw, left_sw};

    // Debounce next state: a new level is accepted only after DEB_CYCLES differing samples.
    always_comb begin
        w_stable_d = r_stable;
        w_accept   = '0;
        w_cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_stable_d[i] = r_sync2[i];
                    w_accept[i]   = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Button FSM: one toggle per press, release only re-arms.
    always_comb begin
        w_btn_d  = r_btn;
        w_toggle = 1'b0;
        unique case (r_btn)
            StBtnUp: begin
                if (w_accept[2] && w_stable_d[2]) begin
                    w_toggle = 1'b1;
                    w_btn_d  = StBtnDown;
                end
            end
            StBtnDown: begin
                if (w_accept[2] && !w_stable_d[2]) begin
                    w_btn_d = StBtnUp;
                end
            end
            default: w_btn_d = StBtnUp;
        endcase
    end

`ifdef TL_HAZ_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(HAZ_TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(HAZ_TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] r_tcnt;
    logic [TCNT_W-1:0] w_tcnt_d;

    // Hazard latch next state; a button toggle takes priority over the timeout.
    always_comb begin
        w_haz_d  = r_haz;
        w_tcnt_d = '0;
        if (w_toggle) begin
            w_haz_d = ~r_haz;
        end else if (r_haz) begin
            if (r_tcnt == TCNT_MAX) begin
                w_haz_d = 1'b0;
            end else begin
                w_tcnt_d = r_tcnt + TCNT_W'(1);
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= w_tcnt_d;
        end
    end
`else
    // Hazard latch next state: changes only on a button toggle.
    always_comb begin
        w_haz_d = r_haz ^ w_toggle;
    end
`endif

    // State registers: synchronisers, debounce, button FSM, hazard latch and outputs.
    // Outputs use next-state values so they move on the same edge as stable/haz.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_cnt      <= '0;
            r_btn      <= StBtnUp;
            r_haz      <= 1'b0;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_hazo     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable   <= w_stable_d;
            r_cnt      <= w_cnt_d;
            r_btn      <= w_btn_d;
            r_haz      <= w_haz_d;
            r_conflict <= w_stable_d[0] & w_stable_d[1];
            r_hazo     <= w_haz_d | (w_stable_d[0] & w_stable_d[1]);
            r_left     <= w_stable_d[0] & ~w_stable_d[1] & ~w_haz_d;
            r_right    <= w_stable_d[1] & ~w_stable_d[0] & ~w_haz_d;
        end
    end

    assign LEFT     = r_left;
    assign RIGHT    = r_right;
    assign HAZ      = r_hazo;
    assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_tail_light_input_conditioner.sv
// Directed bench for tail_light_input_conditioner (DEB_CYCLES=4, HAZ_TIMEOUT_CYCLES=20).
// Output vector compared as {LEFT, RIGHT, HAZ, CONFLICT}.
module tb_tail_light_input_conditioner;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic left_sw  = 1'b0;
    logic right_sw = 1'b0;
    logic haz_btn  = 1'b0;
    logic LEFT;
    logic RIGHT;
    logic HAZ;
    logic CONFLICT;

    int n_checks = 0;
    int n_errors = 0;

`ifdef TL_HAZ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    tail_light_input_conditioner #(
        .DEB_CYCLES         (4),
        .HAZ_TIMEOUT_CYCLES (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .haz_btn  (haz_btn),
        .LEFT     (LEFT),
        .RIGHT    (RIGHT),
        .HAZ      (HAZ),
        .CONFLICT (CONFLICT)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got LRHC=%b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {LEFT, RIGHT, HAZ, CONFLICT};
    endfunction

    initial begin
        // Reset
        tick(3);
        check_eq("reset_hold", outs(), 4'b0000);
        rst_n = 1'b1;
        tick(2);
        check_eq("reset_release", outs(), 4'b0000);

        // 1 Latency: left change sampled at edge N, LEFT visible after N+5
        left_sw = 1'b1;
        tick(5);
        check_eq("lat_n4", outs(), 4'b0000);
        tick(1);
        check_eq("lat_n5", outs(), 4'b1000);
        left_sw = 1'b0;
        tick(8);
        check_eq("lat_release", outs(), 4'b0000);

        // 2 Bounce reject on right lever
        for (int p = 0; p < 3; p++) begin
            right_sw = 1'b1;
            tick(3);
            right_sw = 1'b0;
            tick(1);
        end
        tick(6);
        check_eq("bounce_reject", outs(), 4'b0000);
        right_sw = 1'b1;
        tick(8);
        check_eq("bounce_hold", outs(), 4'b0100);
        right_sw = 1'b0;
        tick(8);
        check_eq("bounce_release", outs(), 4'b0000);

        // 3 Hazard toggle, left lever overridden by hazard
        haz_btn = 1'b1;
        left_sw = 1'b1;
        tick(6);
        check_eq("haz_on_left_masked", outs(), 4'b0010);
        left_sw = 1'b0;
        tick(8);
        check_eq("haz_on_left_off", outs(), 4'b0010);
        tick(36);
        check_eq("haz_held50", outs(), TO_EN ? 4'b0000 : 4'b0010);
        haz_btn = 1'b0;
        tick(8);
        check_eq("haz_released", outs(), TO_EN ? 4'b0000 : 4'b0010);
        haz_btn = 1'b1;
        tick(6);
        check_eq("haz_second_press", outs(), TO_EN ? 4'b0010 : 4'b0000);
        haz_btn = 1'b0;
        tick(30);
        check_eq("haz_idle", outs(), 4'b0000);

        // 4 Conflict
        left_sw  = 1'b1;
        right_sw = 1'b1;
        tick(6);
        check_eq("conflict_on", outs(), 4'b0011);
        right_sw = 1'b0;
        tick(5);
        check_eq("conflict_deb", outs(), 4'b0011);
        tick(1);
        check_eq("conflict_left", outs(), 4'b1000);
        left_sw = 1'b0;
        tick(8);
        check_eq("conflict_idle", outs(), 4'b0000);

        // 5 Reset mid-debounce: left sampled at edge N, reset at edge N+3
        left_sw = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check_eq("rst_mid_hold", outs(), 4'b0000);
        rst_n = 1'b1;
        tick(5);
        check_eq("rst_mid_n8", outs(), 4'b0000);
        tick(1);
        check_eq("rst_mid_n9", outs(), 4'b1000);
        left_sw = 1'b0;
        tick(8);
        check_eq("rst_mid_idle", outs(), 4'b0000);

        // Hazard button held through reset is a fresh press
        haz_btn = 1'b1;
        tick(8);
        check_eq("btn_rst_pre", outs(), 4'b0010);
        rst_n = 1'b0;
        tick(1);
        check_eq("btn_rst_hold", outs(), 4'b0000);
        rst_n = 1'b1;
        tick(5);
        check_eq("btn_rst_deb", outs(), 4'b0000);
        tick(1);
        check_eq("btn_rst_fresh", outs(), 4'b0010);
        haz_btn = 1'b0;
        tick(8);
        haz_btn = 1'b1;
        tick(6);
        check_eq("btn_rst_off", outs(), 4'b0000);
        haz_btn = 1'b0;
        tick(8);

        // 6 Hazard timeout (or persistence without it)
        haz_btn = 1'b1;
        tick(6);
        check_eq("to_on", outs(), 4'b0010);
        haz_btn = 1'b0;
        if (TO_EN) begin
            tick(19);
            check_eq("to_edge19", outs(), 4'b0010);
            tick(1);
            check_eq("to_edge20", outs(), 4'b0000);
        end else begin
            tick(200);
            check_eq("no_to_200", outs(), 4'b0010);
            haz_btn = 1'b1;
            tick(6);
            check_eq("no_to_off", outs(), 4'b0000);
            haz_btn = 1'b0;
        end
        tick(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
